mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency memory between the instruction-fetch requester (IF) and the load/store requester (LS) of the RISC-V core.
- Arbitrates with round-robin and issues one transaction at a time.
- Tracks the outstanding access.
- Returns the read data to whichever requester owns the access.
- Sits between the fetch/LSU stages and the unified memory model at the core top.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency, single-port memory between
// the instruction-fetch (IF) and load/store (LS) requesters. Only one access is
// in flight at a time. The response is steered back to the requester that owns it.
module mem_port_arbiter #(
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    input  logic [AWIDTH-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DWIDTH-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    input  logic [AWIDTH-1:0]   ls_req_addr,
    input  logic                ls_req_write,
    input  logic [DWIDTH-1:0]   ls_req_wdata,
    input  logic [DWIDTH/8-1:0] ls_req_wstrb,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [DWIDTH-1:0]   ls_rsp_data,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [DWIDTH-1:0]   mem_wdata,
    output logic [DWIDTH/8-1:0] mem_wstrb,
    input  logic [DWIDTH-1:0]   mem_rdata
);

    typedef enum logic {StIdle, StWait} state_e;
    typedef enum logic {OwnIf, OwnLs} req_e;

    localparam logic [3:0] LatCnt = 4'(MEM_LATENCY);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    req_e       owner_q, owner_d;
    req_e       last_q, last_d;
    logic       store_q, store_d;

    logic rsp_now;
    logic free;
    logic grant_if;
    logic grant_ls;

    // A new grant may overlap the response cycle so accesses can stream back-to-back.
    assign rsp_now  = (state_q == StWait) && (cnt_q == 4'd1);
    assign free     = (state_q == StIdle) || rsp_now;
    assign grant_if = reset && free && if_req_valid && (!ls_req_valid || last_q == OwnLs);
    assign grant_ls = reset && free && ls_req_valid && (!if_req_valid || last_q == OwnIf);

    // Next-state, memory issue and response steering.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        store_d      = store_q;
        if_req_ready = grant_if;
        ls_req_ready = grant_ls;
        mem_en       = grant_if || grant_ls;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = '0;

        if (grant_if) begin
            mem_addr = if_req_addr;
        end else if (grant_ls) begin
            mem_addr = ls_req_addr;
            mem_we   = ls_req_write;
            if (ls_req_write) begin
                mem_wdata = ls_req_wdata;
                mem_wstrb = ls_req_wstrb;
            end
        end

        if (reset && rsp_now) begin
            if (owner_q == OwnIf) begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = mem_rdata;
            end else begin
                ls_rsp_valid = 1'b1;
                ls_rsp_data  = store_q ? '0 : mem_rdata;
            end
        end

        if (grant_if || grant_ls) begin
            state_d = StWait;
            cnt_d   = LatCnt;
            owner_d = grant_ls ? OwnLs : OwnIf;
            last_d  = grant_ls ? OwnLs : OwnIf;
            store_d = grant_ls && ls_req_write;
        end else if (rsp_now) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // State register with synchronous active-low reset; an in-flight access is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= OwnIf;
            last_q  <= OwnIf;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            store_q <= store_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 1, 2, 3) share one stimulus
// stream; a cycle-based transaction model checks every output of every instance
// each cycle, and directed literal checks pin the model on the key scenarios.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        ls_valid;
    logic [31:0] ls_addr;
    logic        ls_write;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] rdata;

    logic        if_rdy[3];
    logic        if_rv[3];
    logic [31:0] if_rd[3];
    logic        ls_rdy[3];
    logic        ls_rv[3];
    logic [31:0] ls_rd[3];
    logic        m_en[3];
    logic        m_we[3];
    logic [31:0] m_addr[3];
    logic [31:0] m_wdata[3];
    logic [3:0]  m_wstrb[3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state: an absolute cycle number for the pending response.
    bit m_pend[3];
    int m_rsp[3];
    bit m_own_ls[3];
    bit m_store[3];
    bit m_last_ls[3];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(
            .AWIDTH(32),
            .DWIDTH(32),
            .MEM_LATENCY(g + 1)
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .if_req_valid(if_valid),
            .if_req_addr(if_addr),
            .if_req_ready(if_rdy[g]),
            .if_rsp_valid(if_rv[g]),
            .if_rsp_data(if_rd[g]),
            .ls_req_valid(ls_valid),
            .ls_req_addr(ls_addr),
            .ls_req_write(ls_write),
            .ls_req_wdata(ls_wdata),
            .ls_req_wstrb(ls_wstrb),
            .ls_req_ready(ls_rdy[g]),
            .ls_rsp_valid(ls_rv[g]),
            .ls_rsp_data(ls_rd[g]),
            .mem_en(m_en[g]),
            .mem_we(m_we[g]),
            .mem_addr(m_addr[g]),
            .mem_wdata(m_wdata[g]),
            .mem_wstrb(m_wstrb[g]),
            .mem_rdata(rdata)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare all outputs of all instances against the model, then advance the model.
    task automatic model_cycle();
        for (int k = 0; k < 3; k++) begin
            bit          rsp, free, gif, gls;
            logic [31:0] e_addr, e_wdata, e_ifd, e_lsd;
            logic [3:0]  e_strb;
            string       p;
            p      = $sformatf("L%0d ", k + 1);
            rsp    = reset && m_pend[k] && (cyc == m_rsp[k]);
            free   = !m_pend[k] || rsp;
            gif    = reset && free && if_valid && (!ls_valid || m_last_ls[k]);
            gls    = reset && free && ls_valid && (!if_valid || !m_last_ls[k]);
            e_addr = gif ? if_addr : (gls ? ls_addr : 32'h0);
            e_wdata = (gls && ls_write) ? ls_wdata : 32'h0;
            e_strb  = (gls && ls_write) ? ls_wstrb : 4'h0;
            e_ifd   = (rsp && !m_own_ls[k]) ? rdata : 32'h0;
            e_lsd   = (rsp && m_own_ls[k] && !m_store[k]) ? rdata : 32'h0;
            chk({p, "if_req_ready"}, 32'(if_rdy[k]), 32'(gif));
            chk({p, "ls_req_ready"}, 32'(ls_rdy[k]), 32'(gls));
            chk({p, "mem_en"}, 32'(m_en[k]), 32'(gif || gls));
            chk({p, "mem_we"}, 32'(m_we[k]), 32'(gls && ls_write));
            chk({p, "mem_addr"}, m_addr[k], e_addr);
            chk({p, "mem_wdata"}, m_wdata[k], e_wdata);
            chk({p, "mem_wstrb"}, 32'(m_wstrb[k]), 32'(e_strb));
            chk({p, "if_rsp_valid"}, 32'(if_rv[k]), 32'(rsp && !m_own_ls[k]));
            chk({p, "if_rsp_data"}, if_rd[k], e_ifd);
            chk({p, "ls_rsp_valid"}, 32'(ls_rv[k]), 32'(rsp && m_own_ls[k]));
            chk({p, "ls_rsp_data"}, ls_rd[k], e_lsd);
            if (!reset) begin
                m_pend[k]    = 1'b0;
                m_last_ls[k] = 1'b0;
            end else if (gif || gls) begin
                m_pend[k]    = 1'b1;
                m_rsp[k]     = cyc + k + 1;
                m_own_ls[k]  = gls;
                m_store[k]   = gls && ls_write;
                m_last_ls[k] = gls;
            end else if (rsp) begin
                m_pend[k] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic half();
        @(negedge clock);
        model_cycle();
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        half();
        adv();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        if_valid = 1'b0;
        ls_valid = 1'b0;
        ls_write = 1'b0;
        rdata    = 32'h0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        if_valid = 1'b1;
        ls_valid = 1'b1;
        if_addr  = 32'h0;
        ls_addr  = 32'h0;
        ls_write = 1'b0;
        ls_wdata = 32'h0;
        ls_wstrb = 4'h0;
        rdata    = 32'h0;

        // Reset hold with both requesters asserting.
        for (int i = 0; i < 3; i++) begin
            half();
            chk("rst if_req_ready", 32'(if_rdy[1]), 32'd0);
            chk("rst ls_req_ready", 32'(ls_rdy[1]), 32'd0);
            chk("rst mem_en", 32'(m_en[1]), 32'd0);
            chk("rst if_rsp_valid", 32'(if_rv[1]), 32'd0);
            chk("rst ls_rsp_valid", 32'(ls_rv[1]), 32'd0);
            adv();
        end

        // Single fetch, latency 2.
        do_reset();
        if_valid = 1'b1;
        if_addr  = 32'h100;
        half();
        chk("fetch mem_en", 32'(m_en[1]), 32'd1);
        chk("fetch mem_addr", m_addr[1], 32'h100);
        adv();
        if_valid = 1'b0;
        half();
        chk("fetch early rsp", 32'(if_rv[1]), 32'd0);
        adv();
        rdata = 32'hDEADBEEF;
        half();
        chk("fetch if_rsp_valid", 32'(if_rv[1]), 32'd1);
        chk("fetch if_rsp_data", if_rd[1], 32'hDEADBEEF);
        chk("fetch ls_rsp_valid", 32'(ls_rv[1]), 32'd0);
        adv();
        rdata = 32'h0;
        half();
        chk("fetch rsp pulse", 32'(if_rv[1]), 32'd0);
        adv();
        step();

        // Conflict round-robin, latency 2: LS, -, IF, -, LS.
        do_reset();
        if_valid = 1'b1;
        if_addr  = 32'h0;
        ls_valid = 1'b1;
        ls_addr  = 32'h200;
        ls_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdata = 32'h1000 + 32'(i);
            half();
            chk("rr mem_en", 32'(m_en[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr ls_req_ready", 32'(ls_rdy[1]), (i == 0 || i == 4) ? 32'd1 : 32'd0);
            chk("rr if_req_ready", 32'(if_rdy[1]), (i == 2) ? 32'd1 : 32'd0);
            adv();
        end
        if_valid = 1'b0;
        ls_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Back-to-back fetches, latency 1.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if_valid = (i < 4);
            if_addr  = 32'(4 * i);
            rdata    = (i > 0) ? (32'hA0000000 | 32'(i - 1)) : 32'h0;
            half();
            chk("b2b mem_en", 32'(m_en[0]), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) chk("b2b mem_addr", m_addr[0], 32'(4 * i));
            chk("b2b if_rsp_valid", 32'(if_rv[0]), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("b2b if_rsp_data", if_rd[0], 32'hA0000000 | 32'(i - 1));
            adv();
        end
        rdata = 32'h0;
        step();
        step();

        // Store then load, latency 1.
        do_reset();
        ls_valid = 1'b1;
        ls_write = 1'b1;
        ls_addr  = 32'h40;
        ls_wdata = 32'h12345678;
        ls_wstrb = 4'b0011;
        rdata    = 32'hFFFFFFFF;
        half();
        chk("st mem_we", 32'(m_we[0]), 32'd1);
        chk("st mem_wstrb", 32'(m_wstrb[0]), 32'h3);
        chk("st mem_wdata", m_wdata[0], 32'h12345678);
        adv();
        ls_write = 1'b0;
        ls_addr  = 32'h44;
        half();
        chk("st ls_rsp_valid", 32'(ls_rv[0]), 32'd1);
        chk("st ls_rsp_data", ls_rd[0], 32'h0);
        chk("ld mem_wdata", m_wdata[0], 32'h0);
        adv();
        ls_valid = 1'b0;
        rdata    = 32'h00005555;
        half();
        chk("ld ls_rsp_data", ls_rd[0], 32'h00005555);
        adv();
        rdata = 32'h0;
        for (int i = 0; i < 3; i++) step();

        // Reset mid-operation, latency 3.
        do_reset();
        if_valid = 1'b1;
        if_addr  = 32'h300;
        half();
        chk("mid mem_en", 32'(m_en[2]), 32'd1);
        adv();
        if_valid = 1'b0;
        reset    = 1'b0;
        rdata    = 32'hCAFE0000;
        half();
        chk("mid if_rsp_valid rst", 32'(if_rv[2]), 32'd0);
        adv();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            half();
            chk("mid dropped rsp", 32'(if_rv[2]), 32'd0);
            adv();
        end
        if_valid = 1'b1;
        ls_valid = 1'b1;
        ls_addr  = 32'h500;
        half();
        chk("mid ls first", 32'(ls_rdy[2]), 32'd1);
        chk("mid if waits", 32'(if_rdy[2]), 32'd0);
        adv();
        if_valid = 1'b0;
        ls_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
